// File: rtl/img_rsz_blk_avg_pkg.sv
// Shared types and sizes for the resizer block-average engine.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package ImgRszPkg;

  localparam int PXL_PRIM_COLOR_W    = 8;
  localparam int PXL_PRIM_COLOR_NUM  = 3;
  localparam int RSZ_IMG_WIDTH_SIZE  = 32;
  localparam int RSZ_IMG_HEIGHT_SIZE = 32;
  localparam int BLK_WIDTH_MAX_SZ_W  = 5;
  localparam int BLK_HEIGHT_MAX_SZ_W = 5;

  localparam int RSZ_W_IDX_W      = $clog2(RSZ_IMG_WIDTH_SIZE);
  localparam int RSZ_H_IDX_W      = $clog2(RSZ_IMG_HEIGHT_SIZE);
  // Source coordinates must cover the largest image: resized size times max block size.
  localparam int IMG_WIDTH_IDX_W  = RSZ_W_IDX_W + BLK_WIDTH_MAX_SZ_W;
  localparam int IMG_HEIGHT_IDX_W = RSZ_H_IDX_W + BLK_HEIGHT_MAX_SZ_W;
  // Wide enough for a full block of maximum-valued pixels without overflow.
  localparam int BLK_ACC_W        = PXL_PRIM_COLOR_W + BLK_WIDTH_MAX_SZ_W + BLK_HEIGHT_MAX_SZ_W;
  localparam int SHIFT_W          = 4;

  typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] FcRszPxlData_t;
  typedef logic [PXL_PRIM_COLOR_NUM-1:0][BLK_ACC_W-1:0]        BlkAccData_t;

  // floor(log2(v)); a zero size returns 0, matching the "0 means 1" block-size guard.
  function automatic logic [SHIFT_W-1:0] floorLog2(input logic [7:0] v);
    logic [SHIFT_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = SHIFT_W'(i);
    end
    return r;
  endfunction

  // Divide a block sum by 2^sh and keep the low colour bits.
  function automatic logic [PXL_PRIM_COLOR_W-1:0] avgTrunc(input logic [BLK_ACC_W-1:0] s,
                                                           input logic [SHIFT_W-1:0]   sh);
    logic [BLK_ACC_W-1:0] t;
    t = s >> sh;
    return t[PXL_PRIM_COLOR_W-1:0];
  endfunction

endpackage

// File: rtl/img_rsz_blk_avg_pos_cnt.sv
// Block position tracker: where each accepted pixel sits inside its block and in the resized grid.
// Latency: flags are combinational on the current pixel; counters step on the accepting edge.
// Backpressure: advances only on an input handshake, so a stalled stream freezes the position.
module img_rsz_blk_pos_cnt
  import ImgRszPkg::*;
(
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           InHsk,
  input  logic [IMG_WIDTH_IDX_W-1:0]     PxlX,
  input  logic [IMG_HEIGHT_IDX_W-1:0]    PxlY,
  input  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor,
  input  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer,
  output logic [RSZ_W_IDX_W-1:0]         BlkCol,
  output logic [RSZ_H_IDX_W-1:0]         BlkRow,
  output logic                           BlkFirst,
  output logic                           BlkDone,
  output logic                           LastBlk
);

  localparam logic [BLK_WIDTH_MAX_SZ_W-1:0]  HOR_ONE  = BLK_WIDTH_MAX_SZ_W'(1);
  localparam logic [BLK_HEIGHT_MAX_SZ_W-1:0] VER_ONE  = BLK_HEIGHT_MAX_SZ_W'(1);
  localparam logic [RSZ_W_IDX_W-1:0]         COL_ONE  = RSZ_W_IDX_W'(1);
  localparam logic [RSZ_H_IDX_W-1:0]         ROW_ONE  = RSZ_H_IDX_W'(1);
  localparam logic [RSZ_W_IDX_W-1:0]         COL_LAST = RSZ_W_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
  localparam logic [RSZ_H_IDX_W-1:0]         ROW_LAST = RSZ_H_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1);

  logic [BLK_WIDTH_MAX_SZ_W-1:0]  InBlkXQ, InBlkX, HorLast;
  logic [BLK_HEIGHT_MAX_SZ_W-1:0] InBlkYQ, InBlkY, VerLast;
  logic [RSZ_W_IDX_W-1:0]         BlkColQ;
  logic [RSZ_H_IDX_W-1:0]         BlkRowQ;
  logic                           Resync, HorEnd, VerEnd, ColEnd, RowEnd;

  // Effective position of the current pixel, with the origin resync applied, and block flags
  always_comb begin
    Resync   = InHsk && (PxlX == '0) && (PxlY == '0);
    HorLast  = (BlkSzHor == '0) ? '0 : BlkSzHor - HOR_ONE;
    VerLast  = (BlkSzVer == '0) ? '0 : BlkSzVer - VER_ONE;
    InBlkX   = Resync ? '0 : InBlkXQ;
    InBlkY   = Resync ? '0 : InBlkYQ;
    BlkCol   = Resync ? '0 : BlkColQ;
    BlkRow   = Resync ? '0 : BlkRowQ;
    HorEnd   = (InBlkX == HorLast);
    VerEnd   = (InBlkY == VerLast);
    ColEnd   = (BlkCol == COL_LAST);
    RowEnd   = (BlkRow == ROW_LAST);
    BlkFirst = (InBlkX == '0) && (InBlkY == '0);
    BlkDone  = HorEnd && VerEnd;
    LastBlk  = BlkDone && ColEnd && RowEnd;
  end

  // Raster-order advance: pixel-in-block, then block column, then line-in-block, then block row
  always_ff @(posedge Clk) begin
    if (Reset) begin
      InBlkXQ <= '0;
      InBlkYQ <= '0;
      BlkColQ <= '0;
      BlkRowQ <= '0;
    end else if (InHsk) begin
      InBlkXQ <= InBlkX + HOR_ONE;
      InBlkYQ <= InBlkY;
      BlkColQ <= BlkCol;
      BlkRowQ <= BlkRow;
      if (HorEnd) begin
        InBlkXQ <= '0;
        BlkColQ <= BlkCol + COL_ONE;
        if (ColEnd) begin
          InBlkYQ <= InBlkY + VER_ONE;
          if (VerEnd) begin
            InBlkYQ <= '0;
            BlkRowQ <= BlkRow + ROW_ONE;
          end
        end
      end
    end
  end

endmodule

// File: rtl/img_rsz_blk_avg.sv
// Resizer compute engine: averages each BlkSzHor x BlkSzVer block into one resized pixel.
// Latency: 1 cycle from the last pixel of a block to RszPxlVld.
// Backpressure: single output register; PxlRdy_d1 = ~RszPxlVld | RszPxlRdy (pass-through ready).
module img_rsz_blk_avg
  import ImgRszPkg::*;
(
  input  logic                           Clk,
  input  logic                           Reset,
  input  FcRszPxlData_t                  PxlData_d1,
  input  logic [IMG_WIDTH_IDX_W-1:0]     PxlX_d1,
  input  logic [IMG_HEIGHT_IDX_W-1:0]    PxlY_d1,
  input  logic                           PxlVld_d1,
  output logic                           PxlRdy_d1,
  input  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor,
  input  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer,
  output FcRszPxlData_t                  RszPxlData,
  output logic [RSZ_W_IDX_W-1:0]         RszPxlX,
  output logic [RSZ_H_IDX_W-1:0]         RszPxlY,
  output logic                           RszPxlVld,
  input  logic                           RszPxlRdy,
  output logic                           FwdRszEn
);

  logic                   InHsk;
  logic [RSZ_W_IDX_W-1:0] BlkCol;
  logic [RSZ_H_IDX_W-1:0] BlkRow;
  logic                   BlkFirst, BlkDone, LastBlk;
  logic [SHIFT_W-1:0]     Shift;
  logic                   RszLast;
  BlkAccData_t            AccSum;
  // One running sum per block column; only one block row is open at a time.
  BlkAccData_t            Acc [RSZ_IMG_WIDTH_SIZE];

  img_rsz_blk_pos_cnt uPosCnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .InHsk    (InHsk),
    .PxlX     (PxlX_d1),
    .PxlY     (PxlY_d1),
    .BlkSzHor (BlkSzHor),
    .BlkSzVer (BlkSzVer),
    .BlkCol   (BlkCol),
    .BlkRow   (BlkRow),
    .BlkFirst (BlkFirst),
    .BlkDone  (BlkDone),
    .LastBlk  (LastBlk)
  );

  // Handshakes, divider shift and the last-pixel release pulse
  always_comb begin
    PxlRdy_d1 = ~RszPxlVld | RszPxlRdy;
    InHsk     = PxlVld_d1 & PxlRdy_d1;
    Shift     = floorLog2(8'(BlkSzHor)) + floorLog2(8'(BlkSzVer));
    FwdRszEn  = RszPxlVld & RszPxlRdy & RszLast;
  end

  // Block sum including the current pixel; the first pixel of a block restarts the sum
  always_comb begin
    for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
      AccSum[c] = (BlkFirst ? '0 : Acc[BlkCol][c]) + BLK_ACC_W'(PxlData_d1[c]);
    end
  end

  // Accumulator write-back; contents are always overwritten before first use, so no reset
  always_ff @(posedge Clk) begin
    if (InHsk) begin
      Acc[BlkCol] <= AccSum;
    end
  end

  // Output register: load on block completion, hold until accepted
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RszPxlData <= '0;
      RszPxlX    <= '0;
      RszPxlY    <= '0;
      RszPxlVld  <= 1'b0;
      RszLast    <= 1'b0;
    end else if (InHsk && BlkDone) begin
      for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
        RszPxlData[c] <= avgTrunc(AccSum[c], Shift);
      end
      RszPxlX   <= BlkCol;
      RszPxlY   <= BlkRow;
      RszPxlVld <= 1'b1;
      RszLast   <= LastBlk;
    end else if (RszPxlRdy) begin
      RszPxlVld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_img_rsz_blk_avg.sv
// Bench for img_rsz_blk_avg: directed images with hand-computed block averages.
// Latency: checks 1-cycle block-to-output latency and full-rate streaming for 1x1 blocks.
// Backpressure: stalls the output to confirm input ready drops and the data holds.
module tb_img_rsz_blk_avg;
  import ImgRszPkg::*;

  logic                           Clk = 1'b0;
  logic                           Reset;
  FcRszPxlData_t                  PxlData_d1;
  logic [IMG_WIDTH_IDX_W-1:0]     PxlX_d1;
  logic [IMG_HEIGHT_IDX_W-1:0]    PxlY_d1;
  logic                           PxlVld_d1;
  logic                           PxlRdy_d1;
  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor;
  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer;
  FcRszPxlData_t                  RszPxlData;
  logic [RSZ_W_IDX_W-1:0]         RszPxlX;
  logic [RSZ_H_IDX_W-1:0]         RszPxlY;
  logic                           RszPxlVld;
  logic                           RszPxlRdy;
  logic                           FwdRszEn;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int outIdx = 0, base = 0, fwdCnt = 0, stallSeen = 0, stallTarget = 0;
  int expMode = 0, expVal = 100;
  int hsk33Cyc = 0, vld0Cyc = 0, drvStartCyc = 0, drvEndCyc = 0;
  int f0, s0;

  img_rsz_blk_avg dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .PxlData_d1 (PxlData_d1),
    .PxlX_d1    (PxlX_d1),
    .PxlY_d1    (PxlY_d1),
    .PxlVld_d1  (PxlVld_d1),
    .PxlRdy_d1  (PxlRdy_d1),
    .BlkSzHor   (BlkSzHor),
    .BlkSzVer   (BlkSzVer),
    .RszPxlData (RszPxlData),
    .RszPxlX    (RszPxlX),
    .RszPxlY    (RszPxlY),
    .RszPxlVld  (RszPxlVld),
    .RszPxlRdy  (RszPxlRdy),
    .FwdRszEn   (FwdRszEn)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input longint obs, input longint exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic FcRszPxlData_t constPxl(input int v);
    FcRszPxlData_t p;
    for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) p[c] = PXL_PRIM_COLOR_W'(v);
    return p;
  endfunction

  // Distinct per-colour pattern for the 1x1 pass-through image
  function automatic FcRszPxlData_t patPxl(input int x, input int y);
    FcRszPxlData_t p;
    p[0] = PXL_PRIM_COLOR_W'(x * 3 + y);
    p[1] = PXL_PRIM_COLOR_W'(x + y * 5 + 17);
    p[2] = PXL_PRIM_COLOR_W'(x ^ (y << 2));
    return p;
  endfunction

  // pmode 0: constant v; 1: (x%4)+4*(y%4); 2: per-colour pattern
  function automatic FcRszPxlData_t genPxl(input int pmode, input int v, input int x, input int y);
    case (pmode)
      1:       return constPxl((x % 4) + 4 * (y % 4));
      2:       return patPxl(x, y);
      default: return constPxl(v);
    endcase
  endfunction

  // Expected resized pixel number rel within the current test
  function automatic FcRszPxlData_t expPxl(input int mode, input int rel);
    int j;
    j = rel % 1024;
    case (mode)
      1:       return constPxl(7);
      2:       return patPxl(j % 32, j / 32);
      3:       return constPxl((rel < 1024) ? 50 : 200);
      default: return constPxl(expVal);
    endcase
  endfunction

  task automatic sendImage(input int w, input int h, input int pmode, input int v, input int maxPx);
    int n;
    bit abortImg;
    n = 0;
    abortImg = 1'b0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (n < maxPx && !abortImg) begin
          int k;
          PxlData_d1 = genPxl(pmode, v, x, y);
          PxlX_d1    = IMG_WIDTH_IDX_W'(x);
          PxlY_d1    = IMG_HEIGHT_IDX_W'(y);
          PxlVld_d1  = 1'b1;
          k = 0;
          @(negedge Clk);
          while (!PxlRdy_d1 && k < 100) begin
            k++;
            @(negedge Clk);
          end
          if (!PxlRdy_d1) begin
            checkVal("in_rdy_timeout", longint'(PxlRdy_d1), 1);
            abortImg = 1'b1;
          end
          if (n == 0) drvStartCyc = cyc;
          drvEndCyc = cyc;
          if (x == 3 && y == 3) hsk33Cyc = cyc;
          @(posedge Clk);
          #1;
          n++;
        end
      end
    end
    PxlVld_d1 = 1'b0;
  endtask

  task automatic waitOut(input string tag, input int n);
    int k;
    k = 0;
    while ((outIdx - base) < n && k < 300) begin
      k++;
      @(posedge Clk);
    end
    repeat (4) @(posedge Clk);
    #1;
    checkVal(tag, longint'(outIdx - base), longint'(n));
  endtask

  // Output monitor: scoreboard against raster index, stall checks, ready generation
  initial begin
    int rel;
    RszPxlRdy = 1'b1;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        rel = outIdx - base;
        if (RszPxlVld && RszPxlRdy) begin
          checkVal("rsz_x", longint'(RszPxlX), longint'((rel % 1024) % 32));
          checkVal("rsz_y", longint'(RszPxlY), longint'((rel % 1024) / 32));
          checkVal("rsz_data", longint'(RszPxlData), longint'(expPxl(expMode, rel)));
          if (rel == 0) vld0Cyc = cyc;
          outIdx++;
        end
        if (RszPxlVld && !RszPxlRdy) begin
          checkVal("stall_in_rdy", longint'(PxlRdy_d1), 0);
          checkVal("stall_data", longint'(RszPxlData), longint'(expPxl(expMode, rel)));
          stallSeen++;
        end
        if (FwdRszEn) begin
          fwdCnt++;
          checkVal("fwd_pos", longint'(rel % 1024), 1023);
        end
      end
      @(posedge Clk);
      #1;
      RszPxlRdy = (stallSeen >= stallTarget);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset      = 1'b1;
    PxlVld_d1  = 1'b0;
    PxlData_d1 = '0;
    PxlX_d1    = '0;
    PxlY_d1    = '0;
    BlkSzHor   = 5'd2;
    BlkSzVer   = 5'd2;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkVal("rst_vld", longint'(RszPxlVld), 0);
    checkVal("rst_fwd", longint'(FwdRszEn), 0);
    checkVal("rst_data", longint'(RszPxlData), 0);
    checkVal("rst_x", longint'(RszPxlX), 0);
    checkVal("rst_y", longint'(RszPxlY), 0);
    checkVal("rst_in_rdy", longint'(PxlRdy_d1), 1);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // 64x64, 2x2 blocks, constant 100
    base = outIdx; f0 = fwdCnt; expMode = 0; expVal = 100;
    sendImage(64, 64, 0, 100, 4096);
    waitOut("t1_count", 1024);
    checkVal("t1_fwd", longint'(fwdCnt - f0), 1);

    // 128x128, 4x4 blocks, ramp pattern averaging to 7
    BlkSzHor = 5'd4; BlkSzVer = 5'd4;
    base = outIdx; f0 = fwdCnt; expMode = 1;
    sendImage(128, 128, 1, 0, 16384);
    waitOut("t2_count", 1024);
    checkVal("t2_latency", longint'(vld0Cyc - hsk33Cyc), 1);
    checkVal("t2_fwd", longint'(fwdCnt - f0), 1);

    // 64x64, 2x2, output stalled 10 cycles on the first result
    BlkSzHor = 5'd2; BlkSzVer = 5'd2;
    base = outIdx; f0 = fwdCnt; s0 = stallSeen; expMode = 0; expVal = 100;
    stallTarget = stallSeen + 10;
    sendImage(64, 64, 0, 100, 4096);
    waitOut("t3_count", 1024);
    checkVal("t3_stall_cycles", longint'(stallSeen - s0), 10);
    checkVal("t3_fwd", longint'(fwdCnt - f0), 1);

    // 32x32, 1x1 blocks: pass-through at full rate
    BlkSzHor = 5'd1; BlkSzVer = 5'd1;
    base = outIdx; f0 = fwdCnt; expMode = 2;
    sendImage(32, 32, 2, 0, 1024);
    checkVal("t4_throughput", longint'(drvEndCyc - drvStartCyc), 1023);
    waitOut("t4_count", 1024);
    checkVal("t4_latency", longint'(vld0Cyc - drvStartCyc), 1);
    checkVal("t4_fwd", longint'(fwdCnt - f0), 1);

    // Reset after 100 pixels, then a fresh full image
    BlkSzHor = 5'd2; BlkSzVer = 5'd2;
    base = outIdx; f0 = fwdCnt; expMode = 0; expVal = 100;
    sendImage(64, 64, 0, 100, 100);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checkVal("t5_rst_vld", longint'(RszPxlVld), 0);
    checkVal("t5_rst_fwd", longint'(FwdRszEn), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    checkVal("t5_pre_count", longint'(outIdx - base), 17);
    checkVal("t5_pre_fwd", longint'(fwdCnt - f0), 0);
    base = outIdx; f0 = fwdCnt;
    sendImage(64, 64, 0, 100, 4096);
    waitOut("t5_count", 1024);
    checkVal("t5_fwd", longint'(fwdCnt - f0), 1);

    // Two back-to-back images: constant 50 then 200
    base = outIdx; f0 = fwdCnt; expMode = 3;
    sendImage(64, 64, 0, 50, 4096);
    sendImage(64, 64, 0, 200, 4096);
    waitOut("t6_count", 2048);
    checkVal("t6_fwd", longint'(fwdCnt - f0), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
